// File: rtl/mul_iter_unit.sv
// Iterative shift-add multiplier with accumulate for the EX stage.
// Retires STEP_BITS multiplier bits per RUN cycle; optional early exit.
module mul_iter_unit #(
  parameter int WIDTH      = 32,
  parameter int STEP_BITS  = 1,
  parameter int EARLY_EXIT = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 signed_i,
  input  logic [1:0]           acc_mode_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  input  logic [2*WIDTH-1:0]   acc_i,
  input  logic                 start_i,
  input  logic                 cancel_i,
  output logic                 busy_o,
  output logic                 ready_o,
  output logic [2*WIDTH-1:0]   result_o
);

  localparam int N  = WIDTH / STEP_BITS;
  localparam int CW = $clog2(N + 1);
  localparam int W2 = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [W2-1:0]    mcand;
  logic [W2-1:0]    partial;
  logic [W2-1:0]    acc;
  logic [W2-1:0]    result;
  logic [WIDTH-1:0] mplier;
  logic [1:0]       mode;
  logic             neg;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [W2-1:0]    digit;
  logic [W2-1:0]    partial_nx;
  logic [WIDTH-1:0] mplier_sh;
  logic [CW-1:0]    cnt_nx;
  logic             run_last;
  logic [W2-1:0]    p;
  logic [W2-1:0]    fix_val;

  always_comb begin
    a_mag = (signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
    b_mag = (signed_i && b_i[WIDTH-1]) ? -b_i : b_i;
    digit = {{(W2-STEP_BITS){1'b0}}, mplier[STEP_BITS-1:0]};
    partial_nx = partial + mcand * digit;
    mplier_sh = mplier >> STEP_BITS;
    cnt_nx = cnt + CW'(1);
    run_last = (cnt_nx == CW'(N)) ||
               ((EARLY_EXIT != 0) && (mplier_sh == '0));
    p = neg ? -partial : partial;
    unique case (mode)
      2'b01:   fix_val = acc + p;
      2'b10:   fix_val = acc - p;
      default: fix_val = p;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start_i)  state_nx = RUN;
      RUN:  if (run_last) state_nx = FIX;
      FIX:  state_nx = DONE;
      DONE: if (!start_i) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    // flush wins over any FSM move, including a start in IDLE
    if (cancel_i) state_nx = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand   <= '0;
      partial <= '0;
      acc     <= '0;
      result  <= '0;
      mplier  <= '0;
      mode    <= '0;
      neg     <= 1'b0;
      cnt     <= '0;
    end else if (cancel_i) begin
      result  <= '0;
    end else begin
      unique case (state)
        IDLE: if (start_i) begin
          mcand   <= {{WIDTH{1'b0}}, a_mag};
          mplier  <= b_mag;
          acc     <= acc_i;
          mode    <= acc_mode_i;
          neg     <= signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
          partial <= '0;
          cnt     <= '0;
        end
        RUN: begin
          partial <= partial_nx;
          mcand   <= mcand << STEP_BITS;
          mplier  <= mplier_sh;
          cnt     <= cnt_nx;
        end
        FIX:  result <= fix_val;
        DONE: if (!start_i) result <= '0;
        default: ;
      endcase
    end
  end

  assign busy_o   = (state == RUN) || (state == FIX);
  assign ready_o  = (state == DONE);
  assign result_o = result;

endmodule

// File: tb/tb_mul_iter_unit.sv
// Bench for mul_iter_unit: three parameter sets share one stimulus bus.
// Vector table plus scoreboard queue, with cancel/reset/hold sequences.
module tb_mul_iter_unit;

  logic        clk;
  logic        rst;
  logic        signed_i;
  logic [1:0]  acc_mode_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic [63:0] acc_i;
  logic        start_i;
  logic        cancel_i;
  logic [2:0]  busy;
  logic [2:0]  ready;
  logic [63:0] res [3];

  int checks = 0;
  int errors = 0;
  logic [63:0] sb [$];

  typedef struct {
    logic        sgn;
    logic [1:0]  mode;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] acc;
    logic [63:0] exp;
    int          dut;
    int          lat;
  } vec_t;

  vec_t vt [12];

  mul_iter_unit #(.WIDTH(32), .STEP_BITS(1), .EARLY_EXIT(0)) u0 (
    .clk(clk), .rst(rst), .signed_i(signed_i), .acc_mode_i(acc_mode_i),
    .a_i(a_i), .b_i(b_i), .acc_i(acc_i), .start_i(start_i),
    .cancel_i(cancel_i), .busy_o(busy[0]), .ready_o(ready[0]),
    .result_o(res[0]));

  mul_iter_unit #(.WIDTH(32), .STEP_BITS(1), .EARLY_EXIT(1)) u1 (
    .clk(clk), .rst(rst), .signed_i(signed_i), .acc_mode_i(acc_mode_i),
    .a_i(a_i), .b_i(b_i), .acc_i(acc_i), .start_i(start_i),
    .cancel_i(cancel_i), .busy_o(busy[1]), .ready_o(ready[1]),
    .result_o(res[1]));

  mul_iter_unit #(.WIDTH(32), .STEP_BITS(4), .EARLY_EXIT(0)) u2 (
    .clk(clk), .rst(rst), .signed_i(signed_i), .acc_mode_i(acc_mode_i),
    .a_i(a_i), .b_i(b_i), .acc_i(acc_i), .start_i(start_i),
    .cancel_i(cancel_i), .busy_o(busy[2]), .ready_o(ready[2]),
    .result_o(res[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic sgn, input logic [1:0] mode,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [63:0] acc, input logic [63:0] exp,
                              input int dut, input int lat);
    vec_t v;
    v.sgn = sgn; v.mode = mode; v.a = a; v.b = b;
    v.acc = acc; v.exp = exp; v.dut = dut; v.lat = lat;
    return v;
  endfunction

  function automatic logic [63:0] model(input logic sgn, input logic [1:0] mode,
                                        input logic [31:0] a, input logic [31:0] b,
                                        input logic [63:0] acc);
    logic [63:0] ax, bx, pr;
    ax = sgn ? {{32{a[31]}}, a} : {32'h0, a};
    bx = sgn ? {{32{b[31]}}, b} : {32'h0, b};
    pr = ax * bx;
    case (mode)
      2'b01:   return acc + pr;
      2'b10:   return acc - pr;
      default: return pr;
    endcase
  endfunction

  task automatic wait_idle();
    for (int k = 0; k < 100; k++) begin
      if (busy == 3'b0 && ready == 3'b0) return;
      @(posedge clk); #1;
    end
    checks++; errors++;
    $display("FAIL idle_timeout: got busy=%b ready=%b expected 0", busy, ready);
  endtask

  // Called 1 time unit after an edge; that edge is edge 0.
  task automatic run_op(input vec_t v, input int hold);
    int edges;
    bit busy_ok;
    logic [63:0] e, held;
    signed_i = v.sgn; acc_mode_i = v.mode;
    a_i = v.a; b_i = v.b; acc_i = v.acc;
    start_i = 1'b1;
    sb.push_back(v.exp);
    edges = 0;
    busy_ok = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      edges++;
      if (ready[v.dut]) break;
      if (!busy[v.dut]) busy_ok = 1'b0;
    end
    e = sb.pop_front();
    if (!ready[v.dut]) begin
      checks++; errors++;
      $display("FAIL ready_timeout: got ready=0 expected 1 (dut %0d)", v.dut);
    end else begin
      chk($sformatf("result_d%0d", v.dut), res[v.dut], e);
      if (v.lat != 0) chk($sformatf("latency_d%0d", v.dut), 64'(edges), 64'(v.lat));
      chk($sformatf("busy_run_d%0d", v.dut), 64'(busy_ok), 64'd1);
    end
    held = res[v.dut];
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      chk("hold_ready", 64'(ready[v.dut]), 64'd1);
      chk("hold_result", res[v.dut], held);
    end
    start_i = 1'b0;
    @(posedge clk); #1;
    chk("release_ready", 64'(ready[v.dut]), 64'd0);
    chk("release_result", res[v.dut], 64'd0);
    wait_idle();
  endtask

  initial begin
    vec_t v;
    logic [63:0] r2;
    rst = 1'b1; start_i = 1'b0; cancel_i = 1'b0;
    signed_i = 1'b0; acc_mode_i = 2'b00;
    a_i = '0; b_i = '0; acc_i = '0;

    vt[0]  = mk(0, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0, 64'hFFFFFFFE_00000001, 0, 34);
    vt[1]  = mk(1, 2'b00, 32'hFFFFFFFD, 32'h5, 64'h0, 64'hFFFFFFFF_FFFFFFF1, 0, 34);
    vt[2]  = mk(1, 2'b00, 32'h80000000, 32'h80000000, 64'h0, 64'h40000000_00000000, 0, 34);
    vt[3]  = mk(0, 2'b00, 32'h80000000, 32'h2, 64'h0, 64'h00000001_00000000, 0, 34);
    vt[4]  = mk(1, 2'b10, 32'h7, 32'h6, 64'd100, 64'h3A, 0, 34);
    vt[5]  = mk(0, 2'b01, 32'h1, 32'h1, 64'hFFFFFFFF_FFFFFFFF, 64'h0, 0, 34);
    vt[6]  = mk(1, 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'd123, 64'h1, 0, 34);
    vt[7]  = mk(0, 2'b00, 32'h1234, 32'h1, 64'h0, 64'h1234, 1, 3);
    vt[8]  = mk(0, 2'b00, 32'h5, 32'h0, 64'h0, 64'h0, 1, 3);
    vt[9]  = mk(1, 2'b00, 32'hFFFFFFFD, 32'h5, 64'h0, 64'hFFFFFFFF_FFFFFFF1, 1, 5);
    vt[10] = mk(0, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0, 64'hFFFFFFFE_00000001, 2, 10);
    vt[11] = mk(1, 2'b10, 32'h7, 32'h6, 64'd100, 64'h3A, 2, 10);

    #12 rst = 1'b0;
    @(posedge clk); #1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_ready", 64'(ready), 64'd0);
    chk("reset_result", res[0] | res[1] | res[2], 64'd0);

    for (int i = 0; i < 12; i++) run_op(vt[i], (i == 0) ? 5 : 0);

    for (int i = 0; i < 6; i++) begin
      v.sgn = 1'($urandom); v.mode = 2'($urandom);
      v.a = $urandom; v.b = $urandom; v.acc = {$urandom, $urandom};
      v.exp = model(v.sgn, v.mode, v.a, v.b, v.acc);
      v.dut = i % 3;
      v.lat = (v.dut == 0) ? 34 : (v.dut == 2) ? 10 : 0;
      run_op(v, 0);
    end

    // flush mid-RUN while start stays high, then restart at once
    signed_i = 1'b0; acc_mode_i = 2'b00; acc_i = '0;
    a_i = 32'hFFFFFFFF; b_i = 32'hFFFFFFFF; start_i = 1'b1;
    for (int k = 1; k < 10; k++) begin @(posedge clk); #1; end
    cancel_i = 1'b1; a_i = 32'd12345; b_i = 32'd678;
    @(posedge clk); #1;
    cancel_i = 1'b0;
    chk("cancel_busy", 64'(busy), 64'd0);
    chk("cancel_ready", 64'(ready), 64'd0);
    chk("cancel_result", res[2], 64'd0);
    run_op(mk(0, 2'b00, 32'd12345, 32'd678, 64'h0, 64'd8369910, 0, 34), 0);

    // async reset while u0 runs and u2 already holds a result
    a_i = 32'hFFFFFFFF; b_i = 32'hFFFFFFFF; start_i = 1'b1;
    for (int k = 0; k < 15; k++) begin @(posedge clk); #1; end
    chk("pre_rst_ready_d2", 64'(ready[2]), 64'd1);
    r2 = res[2];
    chk("pre_rst_result_d2", r2, 64'hFFFFFFFE_00000001);
    #2 rst = 1'b1;
    #1;
    chk("rst_busy_d0", 64'(busy[0]), 64'd0);
    chk("rst_ready_d2", 64'(ready[2]), 64'd0);
    chk("rst_result_d2", res[2], 64'd0);
    start_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
